// File: rtl/bram_block_streamer_pkg.sv
// Shared types and constants for the BRAM block streamer.
package bram_block_streamer_pkg;

  // Cycles from a read request to its data returning from the paired reader.
  localparam int unsigned ReadLatency = 2;

  // The in_flight counter can never exceed the reader latency.
  localparam int unsigned InFlightW = $clog2(ReadLatency + 1);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/bram_block_streamer_if.sv
// Valid/ready block stream with a last flag.
interface bram_block_streamer_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [WIDTH-1:0] block;
  logic             block_valid;
  logic             block_ready;
  logic             block_last;

  modport master (
    output block,
    output block_valid,
    output block_last,
    input  block_ready
  );

  modport slave (
    input  block,
    input  block_valid,
    input  block_last,
    output block_ready
  );

endinterface

// File: rtl/bram_block_streamer_block_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; no write-to-read bypass.
module block_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands if a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> (!full || pop));

endmodule

// File: rtl/bram_block_streamer.sv
// Issues NUM_BLOCKS sequential read requests per pass and re-times the
// fixed-latency read data into a valid/ready stream through a small FIFO.
module bram_block_streamer
  import bram_block_streamer_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned NUM_BLOCKS    = 128,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  output logic                     read_next_block_valid_out,
  input  logic [REGISTER_SIZE-1:0] read_block_in,
  input  logic                     read_block_pipe2_valid_in,
  bram_block_streamer_if.master    stream,
  output logic                     busy_out,
  output logic                     done_out
);

  localparam int unsigned CntW     = $clog2(NUM_BLOCKS) + 1;
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CreditW  = $clog2(FIFO_DEPTH + ReadLatency + 1);

  if (NUM_BLOCKS < 2) begin : g_bad_num_blocks
    $error("NUM_BLOCKS must be at least 2");
  end
  if (FIFO_DEPTH < 3 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two and at least 3");
  end

  state_e                   state_q;
  logic                     busy_q, done_q;
  logic [CntW-1:0]          req_count_q, out_count_q;
  logic [InFlightW-1:0]     in_flight_q, in_flight_d;
  logic [FifoCntW-1:0]      fifo_count;
  logic                     fifo_empty, fifo_full;
  logic [REGISTER_SIZE-1:0] fifo_dout;
  logic                     credit, req, xfer, block_valid, block_last;

  // Words already buffered plus words still on their way must fit the FIFO.
  assign credit = (CreditW'(fifo_count) + CreditW'(in_flight_q)) < CreditW'(FIFO_DEPTH);
  assign req    = (state_q == StStream) && credit;

  assign block_valid = !fifo_empty;
  assign xfer        = block_valid && stream.block_ready;
  assign block_last  = block_valid && (out_count_q == CntW'(NUM_BLOCKS - 1));

  assign read_next_block_valid_out = req;
  assign busy_out                  = busy_q;
  assign done_out                  = done_q;

  // Gate the FIFO head so block is zero whenever nothing is valid.
  assign stream.block       = block_valid ? fifo_dout : '0;
  assign stream.block_valid = block_valid;
  assign stream.block_last  = block_last;

  // Outstanding-request count: up on request, down on returned data.
  always_comb begin
    in_flight_d = in_flight_q;
    if (req && !read_block_pipe2_valid_in) begin
      in_flight_d = in_flight_q + InFlightW'(1);
    end else if (!req && read_block_pipe2_valid_in) begin
      in_flight_d = in_flight_q - InFlightW'(1);
    end
  end

  // Pass control FSM with its counters and registered busy/done.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_count_q <= '0;
      out_count_q <= '0;
      in_flight_q <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      if (xfer) out_count_q <= out_count_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            state_q     <= StStream;
            busy_q      <= 1'b1;
            req_count_q <= '0;
            out_count_q <= '0;
          end
        end
        StStream: begin
          if (req) begin
            req_count_q <= req_count_q + CntW'(1);
            if (req_count_q == CntW'(NUM_BLOCKS - 1)) state_q <= StDrain;
          end
        end
        StDrain: begin
          // The last block leaving means nothing is buffered or outstanding.
          if (xfer && block_last && in_flight_q == '0) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  block_sync_fifo #(
    .WIDTH (REGISTER_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (read_block_pipe2_valid_in),
    .pop   (xfer),
    .din   (read_block_in),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  a_data_expected: assert property (@(posedge clk_in) disable iff (rst_in)
    read_block_pipe2_valid_in |-> (in_flight_q != '0));
  a_fifo_room: assert property (@(posedge clk_in) disable iff (rst_in)
    read_block_pipe2_valid_in |-> (!fifo_full || xfer));
  a_in_flight_bound: assert property (@(posedge clk_in) disable iff (rst_in)
    in_flight_q <= InFlightW'(ReadLatency));

endmodule

// File: tb/tb_bram_block_streamer.sv
// Randomised bench for bram_block_streamer with a fixed-latency reader model
// and a queue-based reference of the expected block stream.
module tb_bram_block_streamer;

  localparam int unsigned W   = 32;
  localparam int unsigned NB  = 8;
  localparam int unsigned FD  = 4;
  localparam int unsigned NB2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0, start2 = 1'b0;
  logic req8, rvalid8, busy8, done8;
  logic req2, rvalid2, busy2, done2;
  logic [W-1:0] rdata8, rdata2;

  bram_block_streamer_if #(.WIDTH(W)) s8 ();
  bram_block_streamer_if #(.WIDTH(W)) s2 ();

  bram_block_streamer #(.REGISTER_SIZE(W), .NUM_BLOCKS(NB), .FIFO_DEPTH(FD)) dut8 (
    .clk_in                    (clk),
    .rst_in                    (rst),
    .start_in                  (start),
    .read_next_block_valid_out (req8),
    .read_block_in             (rdata8),
    .read_block_pipe2_valid_in (rvalid8),
    .stream                    (s8),
    .busy_out                  (busy8),
    .done_out                  (done8)
  );

  bram_block_streamer #(.REGISTER_SIZE(W), .NUM_BLOCKS(NB2), .FIFO_DEPTH(FD)) dut2 (
    .clk_in                    (clk),
    .rst_in                    (rst),
    .start_in                  (start2),
    .read_next_block_valid_out (req2),
    .read_block_in             (rdata2),
    .read_block_pipe2_valid_in (rvalid2),
    .stream                    (s2),
    .busy_out                  (busy2),
    .done_out                  (done2)
  );

  // Reader models: sequential address counter, data = address + 0x100, two cycles late.
  logic [2:0] raddr8;
  logic [1:0] pv8;
  logic [2:0] pa8 [2];
  always @(posedge clk) begin
    if (rst) begin
      raddr8 <= '0;
      pv8    <= '0;
    end else begin
      pv8    <= {pv8[0], req8};
      pa8[1] <= pa8[0];
      pa8[0] <= raddr8;
      if (req8) raddr8 <= raddr8 + 3'd1;
    end
  end
  assign rvalid8 = pv8[1];
  assign rdata8  = 32'h100 + {29'b0, pa8[1]};

  logic       raddr2;
  logic [1:0] pv2;
  logic       pa2 [2];
  always @(posedge clk) begin
    if (rst) begin
      raddr2 <= 1'b0;
      pv2    <= '0;
    end else begin
      pv2    <= {pv2[0], req2};
      pa2[1] <= pa2[0];
      pa2[0] <= raddr2;
      if (req2) raddr2 <= ~raddr2;
    end
  end
  assign rvalid2 = pv2[1];
  assign rdata2  = 32'h100 + {31'b0, pa2[1]};

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: expected {last, data} in transfer order, plus traffic counters.
  logic [32:0] exp_q [$];
  int          xcyc [$];
  int n_req = 0, n_ret = 0, n_xfer = 0, n_done = 0, max_infl = 0, max_occ = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_stable", {s8.block_valid, s8.block_last, s8.block}, {1'b1, prev_word});
      end
      if (s8.block_valid && s8.block_ready) begin
        check_eq("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check_eq("xfer_word", {s8.block_last, s8.block}, exp_q[0]);
          exp_q.delete(0);
        end
        xcyc.push_back(cyc - t0);
      end
      n_req  <= n_req + int'(req8);
      n_ret  <= n_ret + int'(rvalid8);
      n_xfer <= n_xfer + int'(s8.block_valid && s8.block_ready);
      n_done <= n_done + int'(done8);
      if ((n_req + int'(req8)) - (n_ret + int'(rvalid8)) > max_infl)
        max_infl <= (n_req + int'(req8)) - (n_ret + int'(rvalid8));
      if ((n_ret + int'(rvalid8)) - (n_xfer + int'(s8.block_valid && s8.block_ready)) > max_occ)
        max_occ <= (n_ret + int'(rvalid8)) - (n_xfer + int'(s8.block_valid && s8.block_ready));
      prev_stall <= s8.block_valid && !s8.block_ready;
      prev_word  <= {s8.block_last, s8.block};
    end
  end

  logic rand_ready = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) s8.block_ready = 1'($urandom_range(0, 1));
  endtask

  // Accepted start in the current cycle (cycle 0 of the pass).
  task automatic launch();
    for (int i = 0; i < int'(NB); i++) exp_q.push_back({(i == int'(NB) - 1), 32'h100 + i});
    start = 1'b1;
    t0    = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done8 && k < budget) begin
      step();
      k++;
    end
    check_eq("done_seen", done8, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int r0, d0, x0, n2, done2_rel;

  initial begin
    s8.block_ready = 1'b0;
    s2.block_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("rst_state", {req8, busy8, done8, s8.block_valid, s8.block_last, s8.block}, 0);

    // Full-rate pass: blocks in cycles 4..11, done in cycle 12.
    s8.block_ready = 1'b1;
    xcyc.delete();
    r0 = n_req;
    d0 = n_done;
    launch();
    check_eq("t1_busy", busy8, 1);
    wait_done(60);
    check_eq("t1_done_cyc", cyc - t0, 12);
    step();
    check_eq("t1_n_xfer", xcyc.size(), 8);
    check_eq("t1_first_cyc", xcyc[0], 4);
    check_eq("t1_last_cyc", xcyc[xcyc.size()-1], 11);
    check_eq("t1_n_req", n_req - r0, 8);
    check_eq("t1_n_done", n_done - d0, 1);
    check_eq("t1_drained", exp_q.size(), 0);

    // Starts during STREAM and DONE are ignored.
    r0 = n_req;
    launch();
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(60);
    check_eq("t4_done_cyc", cyc - t0, 12);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check_eq("t4_idle", busy8, 0);
    check_eq("t4_n_req", n_req - r0, 8);

    // Downstream stalled through cycle 20, then released.
    s8.block_ready = 1'b0;
    r0 = n_req;
    d0 = n_done;
    x0 = n_xfer;
    launch();
    while (cyc - t0 < 20) step();
    check_eq("t2_req_stalled", n_req - r0, 4);
    check_eq("t2_no_xfer", n_xfer - x0, 0);
    s8.block_ready = 1'b1;
    wait_done(60);
    step();
    check_eq("t2_n_xfer", n_xfer - x0, 8);
    check_eq("t2_n_done", n_done - d0, 1);

    // Three back-to-back passes under random backpressure.
    rand_ready = 1'b1;
    r0 = n_req;
    d0 = n_done;
    x0 = n_xfer;
    for (int p = 0; p < 3; p++) begin
      launch();
      wait_done(400);
      step();
    end
    rand_ready     = 1'b0;
    s8.block_ready = 1'b1;
    step();
    check_eq("t3_n_xfer", n_xfer - x0, 24);
    check_eq("t3_n_req", n_req - r0, 24);
    check_eq("t3_n_done", n_done - d0, 3);
    check_eq("t3_drained", exp_q.size(), 0);
    check_eq("max_in_flight_ok", max_infl <= 2, 1);
    check_eq("max_fifo_occ_ok", max_occ <= int'(FD), 1);

    // Reset mid-pass with data buffered and in flight.
    s8.block_ready = 1'b0;
    launch();
    while (cyc - t0 < 5) step();
    d0  = n_done;
    rst = 1'b1;
    step();
    check_eq("t5_rst_outputs", {req8, busy8, done8, s8.block_valid, s8.block_last, s8.block}, 0);
    rst = 1'b0;
    repeat (10) step();
    check_eq("t5_no_done", n_done - d0, 0);
    s8.block_ready = 1'b1;
    x0 = n_xfer;
    launch();
    wait_done(60);
    step();
    check_eq("t5_n_xfer", n_xfer - x0, 8);
    check_eq("t5_drained", exp_q.size(), 0);

    // Two-block configuration.
    n2        = 0;
    done2_rel = -1;
    start2    = 1'b1;
    t0        = cyc;
    step();
    start2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (s2.block_valid && s2.block_ready) begin
        check_eq("nb2_word", {s2.block_last, s2.block}, {(n2 == 1), 32'h100 + n2});
        n2++;
      end
      if (done2) done2_rel = cyc - t0;
      step();
    end
    check_eq("nb2_n_xfer", n2, 2);
    check_eq("nb2_done_cyc", done2_rel, 6);
    check_eq("nb2_idle", busy2, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
